// File: rtl/uprogram_sequencer_pkg.sv
// Shared microsequencer definitions: word size, microstate width and the STATE_* encodings
// that the microprogram ROM and the sequencer agree on.
package uprogram_sequencer_pkg;

  localparam int unsigned WORD_SIZE = 16;
  localparam int unsigned STATE_W   = 5;

  localparam logic [STATE_W-1:0] STATE_C1       = 5'd0;
  localparam logic [STATE_W-1:0] STATE_C2       = 5'd1;
  localparam logic [STATE_W-1:0] STATE_ADI1     = 5'd2;
  localparam logic [STATE_W-1:0] STATE_WRITE_RT = 5'd3;
  localparam logic [STATE_W-1:0] STATE_LW1      = 5'd4;
  localparam logic [STATE_W-1:0] STATE_LW2      = 5'd5;
  localparam logic [STATE_W-1:0] STATE_LW3      = 5'd6;
  localparam logic [STATE_W-1:0] STATE_SW1      = 5'd7;
  localparam logic [STATE_W-1:0] STATE_SW2      = 5'd8;
  localparam logic [STATE_W-1:0] STATE_HLT1     = 5'd9;

  // Architectural write enables that must never fire during a stall or after halt
  typedef struct packed {
    logic ir_write;
    logic pc_write;
    logic pc_write_cond;
    logic reg_write;
    logic output_port_write;
  } arch_we_t;

  function automatic arch_we_t qualify_we(input arch_we_t we, input logic en);
    return en ? we : '0;
  endfunction

endpackage

// File: rtl/uprogram_sequencer_retire_counter.sv
// Retired-instruction counter: COUNT_W-bit enable counter, wraps modulo 2^COUNT_W.
module uprogram_sequencer_retire_counter #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [COUNT_W-1:0] count
);

  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/uprogram_sequencer.sv
// Microsequencer state register for the multicycle control path: stalls on slow memory,
// gates write strobes, latches halt, counts retirements. Optional memory timeout: SEQ_MEM_TIMEOUT_EN.
module uprogram_sequencer
  import uprogram_sequencer_pkg::*;
#(
  parameter int unsigned COUNT_W = 16
`ifdef SEQ_MEM_TIMEOUT_EN
  , parameter int unsigned MEM_TIMEOUT = 15
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] nextstate,
  input  logic                 rom_ir_write,
  input  logic                 rom_pc_write,
  input  logic                 rom_pc_write_cond,
  input  logic                 rom_reg_write,
  input  logic                 rom_mem_read,
  input  logic                 rom_mem_write,
  input  logic                 rom_output_port_write,
  input  logic                 mem_ready,
  output logic [STATE_W-1:0]   state,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 reg_write,
  output logic                 output_port_write,
  output logic                 mem_req,
  output logic                 advance,
  output logic                 stall,
  output logic                 commit,
  output logic                 halted,
  output logic [COUNT_W-1:0]   num_inst,
  output logic                 mem_error
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic               halted_q;
  logic               halted_d;
  logic               in_hlt1;
  logic               timeout_c;
  arch_we_t           rom_we;
  arch_we_t           qual_we;

  assign in_hlt1 = (state_q == STATE_HLT1);

  // Memory handshake: the request is unqualified so it stays stable across the stall
  assign mem_req = rom_ir_write | rom_mem_read | rom_mem_write;
  assign stall   = !halted_q && mem_req && !mem_ready;
  assign advance = !halted_q && !stall;

  // C2 is never C1, so exactly one retirement per instruction, HLT included
  assign commit = advance && (state_q != STATE_C1) &&
                  ((nextstate == WORD_SIZE'(STATE_C1)) || in_hlt1);

  assign rom_we = '{
    ir_write:          rom_ir_write,
    pc_write:          rom_pc_write,
    pc_write_cond:     rom_pc_write_cond,
    reg_write:         rom_reg_write,
    output_port_write: rom_output_port_write
  };
  assign qual_we = qualify_we(rom_we, advance);

  assign ir_write          = qual_we.ir_write;
  assign pc_write          = qual_we.pc_write;
  assign pc_write_cond     = qual_we.pc_write_cond;
  assign reg_write         = qual_we.reg_write;
  assign output_port_write = qual_we.output_port_write;

  // HLT1 parks the sequencer instead of following the ROM back to fetch
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    if (advance) begin
      if (in_hlt1) begin
        halted_d = 1'b1;
      end else begin
        state_d = nextstate[STATE_W-1:0];
      end
    end
    if (timeout_c) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= STATE_C1;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  assign state  = state_q;
  assign halted = halted_q;

`ifdef SEQ_MEM_TIMEOUT_EN
  localparam int unsigned WAIT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;
  logic              mem_error_q;
  logic              mem_error_d;

  assign timeout_c = stall && (wait_q == WAIT_W'(MEM_TIMEOUT));

  // Stall-cycle counter; timeout is sticky until reset
  always_comb begin
    wait_d      = wait_q;
    mem_error_d = mem_error_q;
    if (advance) begin
      wait_d = '0;
    end else if (stall) begin
      wait_d = wait_q + WAIT_W'(1);
    end
    if (timeout_c) begin
      mem_error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q      <= '0;
      mem_error_q <= 1'b0;
    end else begin
      wait_q      <= wait_d;
      mem_error_q <= mem_error_d;
    end
  end

  assign mem_error = mem_error_q;
`else
  assign timeout_c = 1'b0;
  assign mem_error = 1'b0;
`endif

  uprogram_sequencer_retire_counter #(
    .COUNT_W (COUNT_W)
  ) u_retire_counter (
    .clk   (clk),
    .rst   (reset),
    .en    (commit),
    .count (num_inst)
  );

endmodule
